// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 32-bit timer with prescaler, compare match and level interrupt.
// Register map (Address): 0 CTRL {PENDING(W1C), IE, AUTO_RELOAD, EN}, 1 PRESCALE,
// 2 COMPARE, 3 COUNT.
// Ports:
//   clock      - single I/O clock
//   reset_n    - asynchronous active-low reset
//   Read/Write - access requests, held high until Ack (both high is a write)
//   Address    - register select
//   DataIn     - write data
//   DataOut    - read data, captured from the pre-write value on acceptance
//   Ack        - registered handshake acknowledge
//   Interrupt  - registered level interrupt, PENDING AND IE
module mmio_timer #(
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        Read,
    input  logic        Write,
    input  logic [1:0]  Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ack,
    output logic        Interrupt
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PW     = PRESCALE_WIDTH;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_COMPARE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT    = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    typedef struct packed {
        logic ie;
        logic auto_reload;
        logic en;
    } ctrl_t;

    state_t              state, state_next;
    ctrl_t               ctrl, ctrl_next;
    logic                pending, pending_next;
    logic [PW-1:0]       prescale, prescale_next;
    logic [PW-1:0]       pcnt, pcnt_next;
    logic [DATA_W-1:0]   compare, compare_next;
    logic [DATA_W-1:0]   count, count_next;
    logic [DATA_W-1:0]   data_out_next;
    logic                ack_next, irq_next;
    logic                accept_c, wr_c, tick_c, match_c;

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ctrl      <= '0;
            pending   <= 1'b0;
            prescale  <= '0;
            pcnt      <= '0;
            compare   <= '0;
            count     <= '0;
            DataOut   <= '0;
            Ack       <= 1'b0;
            Interrupt <= 1'b0;
        end else begin
            state     <= state_next;
            ctrl      <= ctrl_next;
            pending   <= pending_next;
            prescale  <= prescale_next;
            pcnt      <= pcnt_next;
            compare   <= compare_next;
            count     <= count_next;
            DataOut   <= data_out_next;
            Ack       <= ack_next;
            Interrupt <= irq_next;
        end
    end

    // Handshake, register access and timer next-state logic
    always_comb begin
        state_next    = state;
        ctrl_next     = ctrl;
        pending_next  = pending;
        prescale_next = prescale;
        pcnt_next     = pcnt;
        compare_next  = compare;
        count_next    = count;
        data_out_next = DataOut;

        // One access per handshake: only the IDLE->ACK edge touches registers
        accept_c = (state == IDLE) && (Read || Write);
        wr_c     = accept_c && Write;
        tick_c   = ctrl.en && (pcnt == prescale);
        match_c  = tick_c && (count == compare);

        case (state)
            IDLE:    if (Read || Write)   state_next = ACK;
            ACK:     if (!Read && !Write) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (accept_c) begin
            case (Address)
                ADDR_CTRL:     data_out_next = DATA_W'({pending, ctrl.ie, ctrl.auto_reload, ctrl.en});
                ADDR_PRESCALE: data_out_next = DATA_W'(prescale);
                ADDR_COMPARE:  data_out_next = compare;
                default:       data_out_next = count;
            endcase
        end

        if (ctrl.en) begin
            pcnt_next = tick_c ? '0 : pcnt + PW'(1);
        end

        if (tick_c) begin
            count_next = (match_c && ctrl.auto_reload) ? '0 : count + DATA_W'(1);
        end

        if (wr_c) begin
            case (Address)
                ADDR_CTRL: begin
                    ctrl_next = ctrl_t'(DataIn[2:0]);
                    if (DataIn[3]) pending_next = 1'b0;
                end
                ADDR_PRESCALE: begin
                    prescale_next = DataIn[PW-1:0];
                    pcnt_next     = '0;
                end
                ADDR_COMPARE: compare_next = DataIn;
                default:      count_next   = DataIn;
            endcase
        end

        // A match on the same edge as a clear must not be lost
        if (match_c) pending_next = 1'b1;

        ack_next = (state_next == ACK);
        irq_next = pending_next && ctrl_next.ie;
    end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: self-checking bench for mmio_timer with an edge-indexed reference model.
module tb_mmio_timer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [1:0]  Address = 2'd0;
    logic [31:0] DataIn = 32'd0;
    logic [31:0] DataOut;
    logic        Ack;
    logic        Interrupt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: timer enabled at edge m_en, ticks every (m_p+1) edges after it,
    // stopped after edge m_dis; matches before edge m_clr were cleared.
    int          m_p, m_en, m_clr, m_dis;
    logic [31:0] m_c0, m_cmp;
    logic        m_auto, m_ie;

    mmio_timer #(.PRESCALE_WIDTH(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .Read      (Read),
        .Write     (Write),
        .Address   (Address),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .Ack       (Ack),
        .Interrupt (Interrupt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Count and pending as seen after edge e_last
    function automatic void model_at(input int e_last, output logic [31:0] cnt, output logic pend);
        cnt  = m_c0;
        pend = 1'b0;
        for (int e = m_en + m_p + 1; e <= e_last && e <= m_dis; e += m_p + 1) begin
            if (cnt == m_cmp) begin
                if (e >= m_clr) pend = 1'b1;
                cnt = m_auto ? 32'd0 : cnt + 32'd1;
            end else begin
                cnt = cnt + 32'd1;
            end
        end
    endfunction

    // One handshake starting at a negedge; accepted on the next posedge (edge number acc)
    task automatic bus_access(input logic wr, input logic rd, input logic [1:0] addr,
                              input logic [31:0] din, output logic [31:0] dout,
                              output logic ack_mid, output logic irq_mid, output int acc);
        Read    = rd;
        Write   = wr;
        Address = addr;
        DataIn  = din;
        acc     = cyc + 1;
        @(negedge clock);
        dout    = DataOut;
        ack_mid = Ack;
        irq_mid = Interrupt;
        Read    = 1'b0;
        Write   = 1'b0;
        @(negedge clock);
    endtask

    task automatic wr_reg(input logic [1:0] addr, input logic [31:0] din, output int acc);
        logic [31:0] d;
        logic a, i;
        bus_access(1'b1, 1'b0, addr, din, d, a, i, acc);
    endtask

    task automatic rd_reg(input logic [1:0] addr, output logic [31:0] dout, output int acc);
        logic a, i;
        bus_access(1'b0, 1'b1, addr, 32'd0, dout, a, i, acc);
    endtask

    task automatic wait_edge(input int target);
        while (cyc + 1 < target) @(negedge clock);
    endtask

    // Stop, clear, program, then enable; records the enable edge in the model
    task automatic setup_timer(input int p, input logic [31:0] cmp, input logic [31:0] c0,
                               input logic [2:0] ctl);
        int acc;
        wr_reg(2'd0, 32'h0, acc);
        wr_reg(2'd0, 32'h8, acc);
        wr_reg(2'd1, 32'(p), acc);
        wr_reg(2'd2, cmp, acc);
        wr_reg(2'd3, c0, acc);
        m_p = p; m_cmp = cmp; m_c0 = c0; m_auto = ctl[1]; m_ie = ctl[2];
        m_clr = 0; m_dis = 32'h7fff_ffff;
        wr_reg(2'd0, 32'(ctl), acc);
        m_en = acc;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int acc;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        n_cmp++; if (DataOut !== 32'd0) begin n_bad++; $display("FAIL reset_dataout: got %h want 0", DataOut); end
        n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", Ack); end
        n_cmp++; if (Interrupt !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", Interrupt); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_reg(2'(a), d, acc);
            n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
        end
    endtask

    task automatic test_handshake();
        logic [31:0] d;
        int acc;
        Write = 1'b1; Address = 2'd2; DataIn = 32'h5;
        n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL hs_ack_pre: got %b want 0", Ack); end
        @(negedge clock);
        n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL hs_ack_rise: got %b want 1", Ack); end
        @(negedge clock);
        n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL hs_ack_hold: got %b want 1", Ack); end
        Write = 1'b0;
        @(negedge clock);
        n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL hs_ack_fall: got %b want 0", Ack); end
        Read = 1'b1; Address = 2'd2;
        @(negedge clock);
        n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL hs_rd_ack: got %b want 1", Ack); end
        n_cmp++; if (DataOut !== 32'h5) begin n_bad++; $display("FAIL hs_rd_data: got %h want 5", DataOut); end
        Read = 1'b0;
        @(negedge clock);
        n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL hs_rd_fall: got %b want 0", Ack); end
        // Read+Write held: one write, DataOut keeps the pre-write value
        Read = 1'b1; Write = 1'b1; Address = 2'd2; DataIn = 32'hA;
        repeat (3) @(negedge clock);
        n_cmp++; if (DataOut !== 32'h5) begin n_bad++; $display("FAIL hs_rw_data: got %h want 5", DataOut); end
        Read = 1'b0; Write = 1'b0;
        @(negedge clock);
        rd_reg(2'd2, d, acc);
        n_cmp++; if (d !== 32'hA) begin n_bad++; $display("FAIL hs_rw_written: got %h want a", d); end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        logic a, irq;
        int acc;
        setup_timer(0, 32'd3, 32'd0, 3'b111);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_cmp++;
            if (Interrupt !== (cyc >= m_en + 4)) begin
                n_bad++; $display("FAIL ar_irq edge+%0d: got %b want %b", cyc - m_en, Interrupt, cyc >= m_en + 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            repeat (i % 2) @(negedge clock);
            rd_reg(2'd3, d, acc);
            n_cmp++;
            if (d !== 32'((acc - 1 - m_en) % 4)) begin
                n_bad++; $display("FAIL ar_count edge+%0d: got %h want %h", acc - m_en, d, 32'((acc - 1 - m_en) % 4));
            end
        end
        while (((cyc + 1 - m_en) % 4) != 1) @(negedge clock);
        bus_access(1'b1, 1'b0, 2'd0, 32'hF, d, a, irq, acc);
        m_clr = acc;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL ar_w1c_irq: got %b want 0", irq); end
        rd_reg(2'd0, d, acc);
        n_cmp++; if (d !== 32'h7) begin n_bad++; $display("FAIL ar_w1c_ctrl: got %h want 7", d); end
    endtask

    task automatic test_prescale_wrap();
        logic [31:0] d;
        int acc;
        int          offs[5] = '{3, 5, 7, 9, 13};
        logic [31:0] want[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h2};
        setup_timer(2, 32'd5, 32'hFFFF_FFFE, 3'b001);
        for (int i = 0; i < 5; i++) begin
            wait_edge(m_en + offs[i]);
            rd_reg(2'd3, d, acc);
            n_cmp++; if (d !== want[i]) begin n_bad++; $display("FAIL pw_count edge+%0d: got %h want %h", acc - m_en, d, want[i]); end
        end
        rd_reg(2'd0, d, acc);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL pw_ctrl: got %h want 1", d); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d, ec;
        logic ep, a, irq;
        int acc;
        // COUNT write on a tick edge
        setup_timer(1, 32'hFFFF, 32'd0, 3'b001);
        while (((cyc + 1 - m_en) % 2) != 0) @(negedge clock);
        wr_reg(2'd3, 32'h10, acc);
        m_c0 = 32'h10; m_en = acc;
        rd_reg(2'd3, d, acc);
        n_cmp++; if (d !== 32'h10) begin n_bad++; $display("FAIL sim_count_write: got %h want 10", d); end
        repeat (3) @(negedge clock);
        rd_reg(2'd3, d, acc);
        model_at(acc - 1, ec, ep);
        n_cmp++; if (d !== ec) begin n_bad++; $display("FAIL sim_count_run: got %h want %h", d, ec); end
        // W1C on a match edge
        setup_timer(0, 32'd4, 32'd0, 3'b111);
        wait_edge(m_en + 10);
        bus_access(1'b1, 1'b0, 2'd0, 32'hF, d, a, irq, acc);
        m_clr = acc;
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL sim_w1c_irq: got %b want 1", irq); end
        rd_reg(2'd0, d, acc);
        n_cmp++; if (d !== 32'hF) begin n_bad++; $display("FAIL sim_w1c_ctrl: got %h want f", d); end
        // Disable and clear away from a match; count then stays frozen
        bus_access(1'b1, 1'b0, 2'd0, 32'hE, d, a, irq, acc);
        m_clr = acc; m_dis = acc;
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL sim_clr_irq: got %b want 0", irq); end
        rd_reg(2'd0, d, acc);
        n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL sim_clr_ctrl: got %h want 6", d); end
        repeat (4) @(negedge clock);
        rd_reg(2'd3, d, acc);
        model_at(acc - 1, ec, ep);
        n_cmp++; if (d !== 32'h4 || d !== ec) begin n_bad++; $display("FAIL sim_frozen: got %h want 4 (model %h)", d, ec); end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        logic a, irq;
        int acc;
        setup_timer(0, 32'd2, 32'd0, 3'b011);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_cmp++; if (Interrupt !== 1'b0) begin n_bad++; $display("FAIL mk_irq_masked edge+%0d: got %b want 0", cyc - m_en, Interrupt); end
        end
        rd_reg(2'd0, d, acc);
        n_cmp++; if (d !== 32'hB) begin n_bad++; $display("FAIL mk_ctrl_pend: got %h want b", d); end
        n_cmp++; if (Interrupt !== 1'b0) begin n_bad++; $display("FAIL mk_irq_prewrite: got %b want 0", Interrupt); end
        bus_access(1'b1, 1'b0, 2'd0, 32'h7, d, a, irq, acc);
        m_ie = 1'b1;
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL mk_irq_unmask: got %b want 1", irq); end
        rd_reg(2'd0, d, acc);
        n_cmp++; if (d !== 32'hF) begin n_bad++; $display("FAIL mk_ctrl_after: got %h want f", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, ec, cmp, c0;
        logic ep, a, irq;
        logic [2:0] ctl;
        int acc, p;
        for (int it = 0; it < 8; it++) begin
            p   = int'($urandom_range(0, 3));
            cmp = 32'($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1) c0 = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           c0 = 32'($urandom_range(0, 8));
            ctl = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
            setup_timer(p, cmp, c0, ctl);
            rd_reg(2'd1, d, acc);
            n_cmp++; if (d !== 32'(p)) begin n_bad++; $display("FAIL rnd_prescale it%0d: got %h want %h", it, d, 32'(p)); end
            for (int k = 0; k < 5; k++) begin
                repeat ($urandom_range(0, 6)) @(negedge clock);
                if ($urandom_range(0, 1) == 1) begin
                    bus_access(1'b0, 1'b1, 2'd3, 32'd0, d, a, irq, acc);
                    model_at(acc - 1, ec, ep);
                    n_cmp++; if (d !== ec) begin n_bad++; $display("FAIL rnd_count it%0d k%0d: got %h want %h", it, k, d, ec); end
                end else begin
                    bus_access(1'b0, 1'b1, 2'd0, 32'd0, d, a, irq, acc);
                    model_at(acc - 1, ec, ep);
                    n_cmp++; if (d !== {28'd0, ep, ctl}) begin n_bad++; $display("FAIL rnd_ctrl it%0d k%0d: got %h want %h", it, k, d, {28'd0, ep, ctl}); end
                end
                model_at(acc, ec, ep);
                n_cmp++; if (irq !== (ep && m_ie)) begin n_bad++; $display("FAIL rnd_irq it%0d k%0d: got %b want %b", it, k, irq, ep && m_ie); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int acc;
        setup_timer(0, 32'd2, 32'd0, 3'b111);
        repeat (3) @(negedge clock);
        Read = 1'b1; Address = 2'd3;
        @(posedge clock);
        #2;
        n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL ar_pre_ack: got %b want 1", Ack); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", Ack); end
        n_cmp++; if (Interrupt !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b want 0", Interrupt); end
        n_cmp++; if (DataOut !== 32'd0) begin n_bad++; $display("FAIL rst_dataout: got %h want 0", DataOut); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL rst_reaccept_ack: got %b want 1", Ack); end
        n_cmp++; if (DataOut !== 32'd0) begin n_bad++; $display("FAIL rst_count: got %h want 0", DataOut); end
        Read = 1'b0;
        @(negedge clock);
        n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack_fall: got %b want 0", Ack); end
        rd_reg(2'd0, d, acc);
        n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_ctrl: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_autoreload();
        test_prescale_wrap();
        test_simultaneous();
        test_masked();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
